// File: rtl/axi_dma_wr.sv
// axi_dma_wr: S2MM engine. Takes a DATA_W-bit AXI-Stream and writes it to
// memory as fixed-length AXI4 INCR bursts, one outstanding burst at a time,
// into a ring buffer [start_address, start_address+cap_size).
//
// Ports:
//   axi_aclk, axi_rst             clock, synchronous active-high reset
//   axis_*                        input stream (tdata/tkeep/tlast/tvalid/tready)
//   axi_aw*, axi_w*, axi_b*       AXI4 write master (address, data, response)
//   write_start                   level; bursts are issued while high
//   write_reset                   in IDLE: reload address, clear counters/error
//   start_address, cap_size       ring base and size, sampled when leaving IDLE
//   current_addr                  address of the next burst
//   run_cycles                    completed ring wraps, modulo 256
//   wr_s2mm_err                   sticky error (bad config or non-OKAY bresp)
//
// Build option WR_TLAST_PAD_EN: an early axis_tlast pads the rest of the
// burst with zero-strobe beats so the next packet begins on a fresh burst.
// Without it, tlast is ignored and the stream packs continuously.

module axi_dma_wr #(
    parameter int DATA_W    = 256,
    parameter int ADDR_W    = 32,
    parameter int BURST_LEN = 16
) (
    input  logic                axi_aclk,
    input  logic                axi_rst,
    input  logic [DATA_W-1:0]   axis_tdata,
    input  logic [DATA_W/8-1:0] axis_tkeep,
    input  logic                axis_tlast,
    input  logic                axis_tvalid,
    output logic                axis_tready,
    output logic [ADDR_W-1:0]   axi_awaddr,
    output logic [7:0]          axi_awlen,
    output logic [2:0]          axi_awsize,
    output logic [1:0]          axi_awburst,
    output logic [3:0]          axi_awcache,
    output logic [2:0]          axi_awprot,
    output logic [3:0]          axi_awid,
    output logic                axi_awvalid,
    input  logic                axi_awready,
    output logic [DATA_W-1:0]   axi_wdata,
    output logic [DATA_W/8-1:0] axi_wstrb,
    output logic                axi_wlast,
    output logic                axi_wvalid,
    input  logic                axi_wready,
    input  logic [1:0]          axi_bresp,
    input  logic                axi_bvalid,
    output logic                axi_bready,
    input  logic                write_start,
    input  logic                write_reset,
    input  logic [ADDR_W-1:0]   start_address,
    input  logic [31:0]         cap_size,
    output logic [ADDR_W-1:0]   current_addr,
    output logic [7:0]          run_cycles,
    output logic                wr_s2mm_err
);

    localparam int BURST_BYTES = BURST_LEN * DATA_W / 8;
    localparam int OFF_W       = $clog2(BURST_BYTES);
    localparam int BEAT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  base, cur_addr, nxt_addr;
    logic [31:0]        size;
    logic [BEAT_W-1:0]  beat;
    logic [7:0]         runs;
    logic               err;
    logic               reload;   // next run starts from start_address
    logic               pad;      // zero-fill rest of burst after early tlast
    logic               cfg_bad, last_beat, w_xfer, wrap;

    assign cfg_bad   = (start_address[OFF_W-1:0] != '0) || (cap_size == '0)
                     || (cap_size[OFF_W-1:0] != '0);
    assign last_beat = (beat == BEAT_W'(BURST_LEN - 1));
    assign w_xfer    = (state == S_W) && axi_wvalid && axi_wready;
    assign nxt_addr  = cur_addr + ADDR_W'(BURST_BYTES);
    assign wrap      = (nxt_addr == base + ADDR_W'(size));

    // fixed burst attributes
    assign axi_awlen    = 8'(BURST_LEN - 1);
    assign axi_awsize   = 3'b101;
    assign axi_awburst  = 2'b01;
    assign axi_awcache  = 4'b0011;
    assign axi_awprot   = 3'b000;
    assign axi_awid     = 4'b0000;
    assign axi_awaddr   = cur_addr;
    assign current_addr = cur_addr;
    assign run_cycles   = runs;
    assign wr_s2mm_err  = err;

    // state register
    always_ff @(posedge axi_aclk) begin
        if (axi_rst) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (!write_reset && write_start && !cfg_bad) state_nxt = S_AW;
            S_AW:   if (axi_awready) state_nxt = S_W;
            S_W:    if (w_xfer && last_beat) state_nxt = S_B;
            S_B:    if (axi_bvalid)
                        state_nxt = (write_start && !write_reset) ? S_AW : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // outputs: W phase is a straight pass-through of the stream
    always_comb begin
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        axis_tready = 1'b0;
        axi_bready  = 1'b0;
        axi_wlast   = 1'b0;
        axi_wdata   = pad ? '0 : axis_tdata;
        axi_wstrb   = pad ? '0 : axis_tkeep;
        case (state)
            S_AW: axi_awvalid = 1'b1;
            S_W: begin
                axi_wlast = last_beat;
                if (pad) begin
                    axi_wvalid = 1'b1;
                end else begin
                    axi_wvalid  = axis_tvalid;
                    axis_tready = axi_wready;
                end
            end
            S_B: axi_bready = 1'b1;
            default: ;
        endcase
    end

`ifndef WR_TLAST_PAD_EN
    logic tlast_unused;
    assign tlast_unused = axis_tlast;
`endif

    // datapath registers
    always_ff @(posedge axi_aclk) begin
        if (axi_rst) begin
            cur_addr <= '0;
            base     <= '0;
            size     <= '0;
            runs     <= '0;
            err      <= 1'b0;
            reload   <= 1'b1;
            pad      <= 1'b0;
            beat     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (write_reset) begin
                        cur_addr <= start_address;
                        runs     <= '0;
                        err      <= 1'b0;
                        reload   <= 1'b1;
                    end else if (write_start) begin
                        if (cfg_bad) begin
                            err <= 1'b1;
                        end else begin
                            base <= start_address;
                            size <= cap_size;
                            if (reload) begin
                                cur_addr <= start_address;
                                reload   <= 1'b0;
                            end
                        end
                    end
                end
                S_AW: if (axi_awready) beat <= '0;
                S_W: if (w_xfer) begin
                    beat <= beat + BEAT_W'(1);
                    if (last_beat) pad <= 1'b0;
`ifdef WR_TLAST_PAD_EN
                    else if (!pad && axis_tlast) pad <= 1'b1;
`endif
                end
                S_B: if (axi_bvalid) begin
                    // a failed response is flagged but the burst still counts
                    if (axi_bresp != 2'b00) err <= 1'b1;
                    if (wrap) begin
                        cur_addr <= base;
                        runs     <= runs + 8'd1;
                    end else begin
                        cur_addr <= nxt_addr;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_dma_wr.sv
// Bench for axi_dma_wr: stream source + BRAM-like slave, a protocol-level
// model checked every cycle, and directed scenarios with literal checks.
module tb_axi_dma_wr;
    localparam int DW = 256;
    localparam int SW = DW / 8;
    localparam int BB = 512;
    localparam int P_IDLE = 0, P_AW = 1, P_W = 2, P_B = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] axis_tdata = '0;
    logic [SW-1:0] axis_tkeep = '0;
    logic          axis_tlast = 1'b0, axis_tvalid = 1'b0, axis_tready;
    logic [31:0]   awaddr;
    logic [7:0]    awlen;
    logic [2:0]    awsize, awprot;
    logic [1:0]    awburst;
    logic [3:0]    awcache, awid;
    logic          awvalid, awready = 1'b0;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          wlast, wvalid, wready = 1'b0;
    logic [1:0]    bresp = 2'b00;
    logic          bvalid = 1'b0, bready;
    logic          write_start = 1'b0, write_reset = 1'b0;
    logic [31:0]   start_address = '0, cap_size = '0;
    logic [31:0]   current_addr;
    logic [7:0]    run_cycles;
    logic          err;

    axi_dma_wr dut (
        .axi_aclk(clk), .axi_rst(rst),
        .axis_tdata(axis_tdata), .axis_tkeep(axis_tkeep), .axis_tlast(axis_tlast),
        .axis_tvalid(axis_tvalid), .axis_tready(axis_tready),
        .axi_awaddr(awaddr), .axi_awlen(awlen), .axi_awsize(awsize),
        .axi_awburst(awburst), .axi_awcache(awcache), .axi_awprot(awprot),
        .axi_awid(awid), .axi_awvalid(awvalid), .axi_awready(awready),
        .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wlast(wlast),
        .axi_wvalid(wvalid), .axi_wready(wready),
        .axi_bresp(bresp), .axi_bvalid(bvalid), .axi_bready(bready),
        .write_start(write_start), .write_reset(write_reset),
        .start_address(start_address), .cap_size(cap_size),
        .current_addr(current_addr), .run_cycles(run_cycles), .wr_s2mm_err(err)
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0, n_mis = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // knobs driven by the scenario
    bit          gap_en = 0, tlast_en = 0;
    int unsigned err_burst = 32'hFFFF_FFFF;

    // source / slave bookkeeping
    int unsigned seq = 0, aw_cnt = 0, b_cnt = 0, pad_cnt = 0, bib = 0;
    bit          pend_b = 0;
    logic [31:0] last_aw = '0;

    // stream source and memory slave: drive at negedge, observe handshakes at +1
    initial forever begin
        @(negedge clk);
        axis_tvalid = gap_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        axis_tdata  = {8{seq}};
        axis_tkeep  = '1;
        axis_tlast  = tlast_en && (bib == 2);
        awready     = gap_en ? ($urandom_range(0, 1) != 0) : 1'b1;
        wready      = gap_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        bvalid      = pend_b && (gap_en ? ($urandom_range(0, 1) != 0) : 1'b1);
        bresp       = (b_cnt == err_burst) ? 2'b10 : 2'b00;
        #1;
        if (rst) begin
            pend_b = 0;
            bib    = 0;
        end else begin
            if (axis_tvalid && axis_tready) seq++;
            if (awvalid && awready) begin aw_cnt++; last_aw = awaddr; end
            if (wvalid && wready) begin
                if (wstrb == '0) pad_cnt++;
                if (wlast) begin pend_b = 1; bib = 0; end
                else bib++;
            end
            if (bvalid && bready) begin pend_b = 0; b_cnt++; end
        end
    end

    // behavioural model: protocol phase, ring address arithmetic, stream order
    int          ph = P_IDLE, m_beat = 0;
    logic [31:0] m_addr = '0, m_base = '0, m_size = '0;
    logic [7:0]  m_runs = '0;
    bit          m_err = 0, m_reload = 1, m_pad = 0, m_live = 0;
    int unsigned m_seq = 0;

    initial forever begin
        bit exp_wv;
        @(negedge clk);
        #2;
        exp_wv = (ph == P_W) && (m_pad || axis_tvalid);
        if (m_live) begin
            chk("awvalid", awvalid, ph == P_AW);
            if (ph == P_AW) chk("awaddr", awaddr, m_addr);
            chk("wvalid", wvalid, exp_wv);
            chk("tready", axis_tready, (ph == P_W) && !m_pad && wready);
            if (exp_wv) begin
                chk("wdata", wdata, m_pad ? 256'h0 : {8{m_seq}});
                chk("wstrb", wstrb, m_pad ? 32'h0 : 32'hFFFF_FFFF);
                chk("wlast", wlast, m_beat == 15);
            end
            chk("bready", bready, ph == P_B);
            chk("current_addr", current_addr, m_addr);
            chk("run_cycles", run_cycles, m_runs);
            chk("err", err, m_err);
        end
        // advance model to the upcoming edge
        if (rst) begin
            ph = P_IDLE; m_addr = '0; m_runs = '0; m_err = 0;
            m_reload = 1; m_pad = 0; m_live = 1;
        end else if (m_live) begin
            case (ph)
                P_IDLE: begin
                    if (write_reset) begin
                        m_addr = start_address; m_runs = '0; m_err = 0; m_reload = 1;
                    end else if (write_start) begin
                        if (start_address % BB != 0 || cap_size == 0 || cap_size % BB != 0)
                            m_err = 1;
                        else begin
                            m_base = start_address; m_size = cap_size;
                            if (m_reload) begin m_addr = start_address; m_reload = 0; end
                            ph = P_AW;
                        end
                    end
                end
                P_AW: if (awready) begin ph = P_W; m_beat = 0; end
                P_W: if (exp_wv && wready) begin
                    if (!m_pad) begin
                        m_seq++;
`ifdef WR_TLAST_PAD_EN
                        if (axis_tlast && m_beat != 15) m_pad = 1;
`endif
                    end
                    m_beat++;
                    if (m_beat == 16) begin ph = P_B; m_pad = 0; end
                end
                P_B: if (bvalid) begin
                    if (bresp != 2'b00) m_err = 1;
                    if (m_addr + BB == m_base + m_size) begin
                        m_addr = m_base; m_runs++;
                    end else m_addr = m_addr + BB;
                    ph = (write_start && !write_reset) ? P_AW : P_IDLE;
                end
                default: ;
            endcase
        end
    end

    task automatic drain();
        int n = 0;
        write_start = 0;
        repeat (3) @(negedge clk);
        while (!(b_cnt == aw_cnt && !awvalid && !wvalid && !bready) && n < 400) begin
            @(negedge clk); n++;
        end
        chk("drain_timeout", n < 400, 1'b1);
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_wreset(input logic [31:0] sa, input logic [31:0] cs);
        @(negedge clk);
        start_address = sa; cap_size = cs; write_reset = 1;
        @(negedge clk);
        write_reset = 0;
    endtask

    initial begin
        int n;
        int unsigned a0, b0, p0;
        repeat (3) @(negedge clk);
        rst = 0;
        #3;
        chk("rst_addr", current_addr, 32'h0);
        chk("rst_runs", run_cycles, 8'h0);
        chk("rst_err", err, 1'b0);
        chk("rst_awvalid", awvalid, 1'b0);
        chk("rst_wvalid", wvalid, 1'b0);
        chk("rst_bready", bready, 1'b0);
        chk("rst_tready", axis_tready, 1'b0);
        chk("awlen", awlen, 8'd15);
        chk("awsize", awsize, 3'b101);
        chk("awburst", awburst, 2'b01);
        chk("awcache", awcache, 4'b0011);
        chk("awprot_awid", {awprot, awid}, 7'h0);

        // misaligned base: error, no address issued
        @(negedge clk);
        start_address = 32'h100; cap_size = 32'h10000; write_start = 1;
        repeat (4) @(negedge clk);
        write_start = 0;
        #3;
        chk("cfg_err", err, 1'b1);
        chk("cfg_no_aw", aw_cnt, 0);

        // write_reset in IDLE clears error and loads base
        pulse_wreset(32'h100, 32'h10000);
        #3;
        chk("wreset_err", err, 1'b0);
        chk("wreset_addr", current_addr, 32'h100);
        pulse_wreset(32'h0, 32'h10000);

        // full ring of 128 bursts
        write_start = 1;
        n = 0;
        while (b_cnt < 128 && n < 5000) begin @(negedge clk); n++; end
        chk("ring_timeout", n < 5000, 1'b1);
        #3;
        chk("ring_runs", run_cycles, 8'd1);
        chk("ring_addr", current_addr, 32'h0);
        n = 0;
        while (aw_cnt < 129 && n < 100) begin @(negedge clk); n++; end
        chk("ring_next_aw", last_aw, 32'h0);
        drain();

        // backpressure on every channel
        gap_en = 1;
        b0 = b_cnt;
        write_start = 1;
        n = 0;
        while (b_cnt < b0 + 6 && n < 3000) begin @(negedge clk); n++; end
        chk("bp_timeout", n < 3000, 1'b1);
        drain();
        gap_en = 0;

        // small ring at 0x1000, slave flags an error on the 3rd burst
        pulse_wreset(32'h1000, 32'h400);
        err_burst = b_cnt + 2;
        write_start = 1;
        n = 0;
        while (b_cnt < err_burst + 3 && n < 1000) begin @(negedge clk); n++; end
        chk("bresp_timeout", n < 1000, 1'b1);
        #3;
        chk("bresp_err", err, 1'b1);
        drain();
        err_burst = 32'hFFFF_FFFF;

        // drop write_start on beat 5: burst finishes, then nothing more
        write_start = 1;
        n = 0;
        while (bib != 5 && n < 200) begin @(negedge clk); n++; end
        chk("stop_timeout", n < 200, 1'b1);
        a0 = aw_cnt; b0 = b_cnt;
        write_start = 0;
        repeat (60) @(negedge clk);
        chk("stop_aw", aw_cnt, a0);
        chk("stop_b", b_cnt, b0 + 1);

        // early tlast on beat 3 of each burst
        tlast_en = 1;
        p0 = pad_cnt; b0 = b_cnt;
        write_start = 1;
        n = 0;
        while (b_cnt < b0 + 2 && n < 500) begin @(negedge clk); n++; end
        chk("pad_timeout", n < 500, 1'b1);
        drain();
        tlast_en = 0;
`ifdef WR_TLAST_PAD_EN
        chk("pad_beats", pad_cnt - p0, 13 * (b_cnt - b0));
`else
        chk("pad_beats", pad_cnt - p0, 0);
`endif

        // axi_rst mid-W
        pulse_wreset(32'h2000, 32'h1000);
        write_start = 1;
        n = 0;
        while (bib != 3 && n < 200) begin @(negedge clk); n++; end
        chk("midw_timeout", n < 200, 1'b1);
        rst = 1; write_start = 0;
        @(negedge clk);
        rst = 0;
        #3;
        chk("midrst_awvalid", awvalid, 1'b0);
        chk("midrst_wvalid", wvalid, 1'b0);
        chk("midrst_bready", bready, 1'b0);
        chk("midrst_addr", current_addr, 32'h0);
        chk("midrst_runs", run_cycles, 8'h0);
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
